// File: rtl/array_drain_pkg.sv
// Shared types and lane width for the systolic-array output drain.
package array_drain_pkg;

   localparam int unsigned NUM_BITS = 8;

   typedef enum logic [1:0] {
      DR_IDLE,
      DR_SKEW,
      DR_CAPTURE,
      DR_FLUSH
   } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO for drained result rows; read data comes straight from the entry registers.
module drain_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             one_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             push_ok, pop_ok;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign push_ok = push_i & (~full_o | pop_i);
   assign pop_ok  = pop_i & ~empty_o;

   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign one_o   = (cnt_q == (PTR_W+1)'(1));
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/array_drain.sv
// Systolic-array output drain: deskews bottom-row columns and buffers whole rows in a FIFO.
// Optional DRAIN_LAST_EN adds out_last_o, tagging the final row of each drain.
module array_drain
   import array_drain_pkg::*;
#(
   parameter int unsigned NUM_COLS   = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned MAX_ROWS   = 256,
   localparam int unsigned ROW_W     = $clog2(MAX_ROWS + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic [ROW_W-1:0]             num_rows_i,
   input  logic [NUM_COLS*NUM_BITS-1:0] col_data_i,
   output logic [NUM_COLS*NUM_BITS-1:0] out_data_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
`ifdef DRAIN_LAST_EN
   output logic                         out_last_o,
`endif
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         overflow_o
);

   localparam int unsigned DATA_W = NUM_COLS * NUM_BITS;
`ifdef DRAIN_LAST_EN
   localparam int unsigned FIFO_W = DATA_W + 1;
`else
   localparam int unsigned FIFO_W = DATA_W;
`endif
   localparam int unsigned SKW_W  = $clog2(NUM_COLS + 1);
   localparam bit          DIRECT = (NUM_COLS == 1);

   drain_state_t      state_q;
   logic [ROW_W-1:0]  rows_q, row_cnt_q;
   logic [SKW_W-1:0]  skew_cnt_q;
   logic              overflow_q, done_q;

   logic [DATA_W-1:0] aligned;
   logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
   logic              fifo_full, fifo_empty, fifo_one;
   logic              cap_idle, cap, cap_last, pop, drop;

   // Lane c arrives c cycles after lane 0, so it needs NUM_COLS-1-c delay stages.
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
      localparam int unsigned D = NUM_COLS - 1 - c;
      if (D == 0) begin : g_direct
         assign aligned[c*NUM_BITS +: NUM_BITS] = col_data_i[c*NUM_BITS +: NUM_BITS];
      end else begin : g_delay
         logic [NUM_BITS-1:0] sr_q [D];
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int unsigned k = 0; k < D; k++) sr_q[k] <= '0;
            end else begin
               sr_q[0] <= col_data_i[c*NUM_BITS +: NUM_BITS];
               for (int unsigned k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
            end
         end
         assign aligned[c*NUM_BITS +: NUM_BITS] = sr_q[D-1];
      end
   end

   // With a single column row 0 is already aligned in the start cycle.
   assign cap_idle = DIRECT && (state_q == DR_IDLE) && start_i && (num_rows_i != '0);
   assign cap      = (state_q == DR_CAPTURE) || cap_idle;
   assign cap_last = cap_idle ? (num_rows_i == ROW_W'(1))
                              : (ROW_W'(row_cnt_q + 1'b1) == rows_q);
   assign pop      = out_valid_o & out_ready_i;
   assign drop     = cap & fifo_full & ~pop;

`ifdef DRAIN_LAST_EN
   assign fifo_wdata = {cap_last, aligned};
   assign out_data_o = fifo_rdata[DATA_W-1:0];
   assign out_last_o = fifo_rdata[DATA_W] & ~fifo_empty;
`else
   assign fifo_wdata = aligned;
   assign out_data_o = fifo_rdata;
`endif

   drain_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cap),
      .pop_i   (pop),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .one_o   (fifo_one)
   );

   assign out_valid_o = ~fifo_empty;
   assign busy_o      = (state_q != DR_IDLE);
   assign done_o      = done_q;
   assign overflow_o  = overflow_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= DR_IDLE;
         rows_q     <= '0;
         row_cnt_q  <= '0;
         skew_cnt_q <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (drop) overflow_q <= 1'b1;
         case (state_q)
            DR_IDLE: begin
               if (start_i) begin
                  rows_q     <= num_rows_i;
                  overflow_q <= 1'b0;
                  row_cnt_q  <= cap_idle ? ROW_W'(1) : '0;
                  skew_cnt_q <= '0;
                  if (num_rows_i == '0)   state_q <= DR_FLUSH;
                  else if (DIRECT)        state_q <= cap_last ? DR_FLUSH : DR_CAPTURE;
                  else if (NUM_COLS == 2) state_q <= DR_CAPTURE;
                  else                    state_q <= DR_SKEW;
               end
            end
            // The start cycle is the first skew cycle, so this state lasts NUM_COLS-2.
            DR_SKEW: begin
               if (skew_cnt_q == SKW_W'(NUM_COLS - 3)) state_q <= DR_CAPTURE;
               else                                    skew_cnt_q <= skew_cnt_q + 1'b1;
            end
            DR_CAPTURE: begin
               row_cnt_q <= row_cnt_q + 1'b1;
               if (cap_last) state_q <= DR_FLUSH;
            end
            // No pushes happen here, so one entry plus a pop means empty next cycle.
            DR_FLUSH: begin
               if (fifo_empty || (fifo_one && pop)) begin
                  done_q  <= 1'b1;
                  state_q <= DR_IDLE;
               end
            end
            default: state_q <= DR_IDLE;
         endcase
      end
   end

endmodule
